// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit CLA slice per stage,
// registered inter-slice carry, valid/ready flow control. Optional macro: CLA_PIPE_SAT_EN.
module cla_pipe_addsub #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             sub_flag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int STAGES = WIDTH / BLOCK;

    logic adv;

    // Stage i register holds the operation about to have slice i computed.
    logic             v_reg   [STAGES];
    logic             sub_reg [STAGES];
    logic             cin_reg [STAGES];
    logic [WIDTH-1:0] a_reg   [STAGES];
    logic [WIDTH-1:0] b_reg   [STAGES];
    logic [WIDTH-1:0] ps_reg  [STAGES];

    logic [WIDTH-1:0] ps_next [STAGES];
    logic             cout_c  [STAGES];
    logic             cmsb_c  [STAGES];

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [BLOCK-1:0] sa;
            logic [BLOCK-1:0] sb;
            logic [BLOCK-1:0] g;
            logic [BLOCK-1:0] p;
            logic [BLOCK:0]   c;
            logic             acc;
            logic             term;
            logic [WIDTH-1:0] ps_next_l;

            // Every carry is a flat sum of generate/propagate products, no rippling.
            always_comb begin
                sa   = a_reg[gi][gi*BLOCK +: BLOCK];
                sb   = b_reg[gi][gi*BLOCK +: BLOCK] ^ {BLOCK{sub_reg[gi]}};
                g    = sa & sb;
                p    = sa ^ sb;
                c    = '0;
                acc  = 1'b0;
                term = 1'b0;
                c[0] = cin_reg[gi];
                for (int j = 0; j < BLOCK; j++) begin
                    acc = cin_reg[gi];
                    for (int t = 0; t <= j; t++) begin
                        acc = acc & p[t];
                    end
                    for (int m = 0; m <= j; m++) begin
                        term = g[m];
                        for (int t = m + 1; t <= j; t++) begin
                            term = term & p[t];
                        end
                        acc = acc | term;
                    end
                    c[j+1] = acc;
                end
            end

            always_comb begin
                ps_next_l                      = ps_reg[gi];
                ps_next_l[gi*BLOCK +: BLOCK]   = p ^ c[BLOCK-1:0];
            end

            assign ps_next[gi] = ps_next_l;
            assign cout_c[gi]  = c[BLOCK];
            assign cmsb_c[gi]  = c[BLOCK-1];

            if (gi == 0) begin : g_load_in
                always_ff @(posedge clk) begin
                    if (rst) begin
                        v_reg[0]   <= 1'b0;
                        sub_reg[0] <= 1'b0;
                        cin_reg[0] <= 1'b0;
                        a_reg[0]   <= '0;
                        b_reg[0]   <= '0;
                        ps_reg[0]  <= '0;
                    end else if (adv) begin
                        v_reg[0] <= in_valid;
                        if (in_valid) begin
                            sub_reg[0] <= sub_flag;
                            cin_reg[0] <= sub_flag;
                            a_reg[0]   <= src1;
                            b_reg[0]   <= src2;
                            ps_reg[0]  <= '0;
                        end
                    end
                end
            end else begin : g_load_prev
                always_ff @(posedge clk) begin
                    if (rst) begin
                        v_reg[gi]   <= 1'b0;
                        sub_reg[gi] <= 1'b0;
                        cin_reg[gi] <= 1'b0;
                        a_reg[gi]   <= '0;
                        b_reg[gi]   <= '0;
                        ps_reg[gi]  <= '0;
                    end else if (adv) begin
                        v_reg[gi] <= v_reg[gi-1];
                        if (v_reg[gi-1]) begin
                            sub_reg[gi] <= sub_reg[gi-1];
                            cin_reg[gi] <= cout_c[gi-1];
                            a_reg[gi]   <= a_reg[gi-1];
                            b_reg[gi]   <= b_reg[gi-1];
                            ps_reg[gi]  <= ps_next[gi-1];
                        end
                    end
                end
            end
        end
    endgenerate

    logic [WIDTH-1:0] raw_sum;
    logic [WIDTH-1:0] res_sum;
    logic             raw_ovf;

    assign raw_sum = ps_next[STAGES-1];
    assign raw_ovf = cout_c[STAGES-1] ^ cmsb_c[STAGES-1];

`ifdef CLA_PIPE_SAT_EN
    // A wrapped-negative result means positive overflow, so clamp to max positive.
    always_comb begin
        res_sum = raw_sum;
        if (raw_ovf) begin
            res_sum = raw_sum[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                       : {1'b1, {(WIDTH-1){1'b0}}};
        end
    end
`else
    assign res_sum = raw_sum;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (adv) begin
            out_valid <= v_reg[STAGES-1];
            if (v_reg[STAGES-1]) begin
                sum       <= res_sum;
                carry_out <= cout_c[STAGES-1];
                overflow  <= raw_ovf;
            end
        end
    end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Scoreboard bench for cla_pipe_addsub (WIDTH=8, BLOCK=4): directed cases, backpressure,
// mid-flight reset and randomized traffic against an integer-arithmetic reference model.
module tb_cla_pipe_addsub;

    localparam int W = 8;
    localparam int B = 4;
    localparam int S = W / B;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] src1 = '0;
    logic [W-1:0] src2 = '0;
    logic         sub_flag = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;

    cla_pipe_addsub #(.WIDTH(W), .BLOCK(B)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src1      (src1),
        .src2      (src2),
        .sub_flag  (sub_flag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int           t;
        bit           lat;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sb;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference: plain signed/unsigned integer arithmetic.
    function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic sb);
        exp_t e;
        int ua, ub, ur, sa, sbv, r;
        ua  = a;
        ub  = b;
        sa  = $signed(a);
        sbv = $signed(b);
        ur  = sb ? ua - ub : ua + ub;
        r   = sb ? sa - sbv : sa + sbv;
        e.s = ur[W-1:0];
        e.c = sb ? (ua >= ub) : (ur >= (1 << W));
        e.o = (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
`ifdef CLA_PIPE_SAT_EN
        if (e.o) e.s = (r > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
        e.t  = cyc;
        e.lat = 1'b0;
        e.a  = a;
        e.b  = b;
        e.sb = sb;
        return e;
    endfunction

    task automatic push(logic [W-1:0] a, logic [W-1:0] b, logic sb, bit lat);
        exp_t e;
        e = model(a, b, sb);
        e.lat = lat;
        q.push_back(e);
    endtask

    // Present one operation and hold it until accepted (bounded).
    task automatic drive(logic [W-1:0] a, logic [W-1:0] b, logic sb, bit lat);
        bit done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; src1 = a; src2 = b; sub_flag = sb;
            @(negedge clk);
            if (in_ready) begin
                push(a, b, sb, lat);
                done = 1'b1;
            end
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", {24'd0, sum}, 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    $display("op %0h %s %0h -> sum=%0h c=%0b ov=%0b", e.a, e.sb ? "-" : "+",
                             e.b, sum, carry_out, overflow);
                    chk("sum", {24'd0, sum}, {24'd0, e.s});
                    chk("carry_out", {31'd0, carry_out}, {31'd0, e.c});
                    chk("overflow", {31'd0, overflow}, {31'd0, e.o});
                    if (e.lat) chk("latency", cyc - e.t, S + 1);
                end
            end
        end
    end

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {24'd0, sum}, 32'd0);
        chk("rst_carry", {31'd0, carry_out}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Back-to-back directed cases, including cross-slice carry isolation
        drive(8'h7F, 8'h01, 1'b0, 1'b1);
        drive(8'hFF, 8'h01, 1'b0, 1'b1);
        drive(8'h05, 8'h07, 1'b1, 1'b1);
        drive(8'h80, 8'h01, 1'b1, 1'b1);
        drive(8'h0F, 8'h0F, 1'b1, 1'b1);
        drive(8'h0F, 8'h01, 1'b0, 1'b1);
        idle(5);

        // Backpressure: fill the pipe with out_ready low
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < S + 1; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; src1 = 8'h30 + 8'(k); src2 = 8'h21; sub_flag = k[0];
            @(negedge clk);
            if (in_ready) push(src1, src2, sub_flag, 1'b0);
        end
        @(posedge clk); #1;
        in_valid = 1'b1; src1 = 8'h11; src2 = 8'h22; sub_flag = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            if (q.size() > 0) chk("stall_sum", {24'd0, sum}, {24'd0, q[0].s});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        if (in_ready) push(src1, src2, sub_flag, 1'b0);
        idle(6);
        chk("drain_empty", q.size(), 32'd0);

        // Reset with two operations in flight
        drive(8'h10, 8'h20, 1'b0, 1'b0);
        drive(8'h33, 8'h44, 1'b1, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        drive(8'h01, 8'h02, 1'b0, 1'b1);
        idle(6);
        chk("post_reset_empty", q.size(), 32'd0);

        // Randomized traffic with random backpressure
        for (int k = 0; k < 10000; k++) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 4) != 0);
            src1      = W'($urandom);
            src2      = W'($urandom);
            sub_flag  = 1'($urandom);
            @(negedge clk);
            if (in_valid && in_ready) push(src1, src2, sub_flag, 1'b0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 50 && q.size() > 0; k++) @(posedge clk);
        idle(2);
        chk("final_empty", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
